// File: rtl/uart_alu_pkg.sv
// Shared types and elaboration helpers for the UART <-> ALU frame controller.
// Byte counts are derived from the operand and byte widths of each instance.
package uart_alu_pkg;

   typedef enum logic [2:0] {
      ST_RX_A,
      ST_RX_B,
      ST_RX_OP,
      ST_EXEC,
      ST_TX
   } ctrl_state_e;

   typedef enum logic [1:0] {
      SER_IDLE,
      SER_LOAD,
      SER_WAIT
   } ser_state_e;

   function automatic int calc_n_bytes(input int nb_operand, input int nb_data);
      return nb_operand / nb_data;
   endfunction

   // Byte-index counters keep at least one bit even for single-byte operands.
   function automatic int idx_width(input int n_bytes);
      return (n_bytes > 1) ? $clog2(n_bytes) : 1;
   endfunction

   function automatic bit params_legal(input int nb_data, input int nb_operand, input int nb_op,
                                       input int nb_timeout, input int timeout_cycles);
      return (nb_data > 0) && (nb_operand >= nb_data) && (nb_operand % nb_data == 0) &&
             (nb_op > 0) && (nb_op <= nb_data) && (timeout_cycles >= 0) &&
             (longint'(timeout_cycles) < (longint'(1) << nb_timeout));
   endfunction

endpackage

// File: rtl/uart_alu_frame_ctrl_serializer.sv
// Sends an ALU result to the UART TX one byte at a time, LSB first, using the
// start/done handshake; done_o pulses with the final byte's tx_done.
module result_tx_serializer
   import uart_alu_pkg::*;
#(
   parameter int NB_DATA    = 8,
   parameter int NB_OPERAND = 16
) (
   input  logic                  clk_i,
   input  logic                  srst_i,
   input  logic                  load_i,
   input  logic [NB_OPERAND-1:0] result_i,
   input  logic                  tx_done_i,
   output logic                  tx_start_o,
   output logic [NB_DATA-1:0]    tx_data_o,
   output logic                  done_o
);
   localparam int               N_BYTES   = calc_n_bytes(NB_OPERAND, NB_DATA);
   localparam int               CNT_W     = idx_width(N_BYTES);
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(N_BYTES - 1);

   ser_state_e            state_q;
   logic [NB_OPERAND-1:0] shift_q;
   logic [NB_OPERAND-1:0] shift_d;
   logic [CNT_W-1:0]      sent_q;
   logic                  tx_start_q;
   logic [NB_DATA-1:0]    tx_data_q;

   assign shift_d = shift_q >> NB_DATA;

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q    <= SER_IDLE;
         shift_q    <= '0;
         sent_q     <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         tx_start_q <= 1'b0;
         case (state_q)
            SER_IDLE: begin
               if (load_i) begin
                  shift_q    <= result_i;
                  sent_q     <= '0;
                  tx_data_q  <= result_i[NB_DATA-1:0];
                  tx_start_q <= 1'b1;
                  state_q    <= SER_LOAD;
               end
            end
            SER_LOAD: state_q <= SER_WAIT;
            SER_WAIT: begin
               if (tx_done_i) begin
                  shift_q <= shift_d;
                  if (sent_q == LAST_BYTE) begin
                     state_q <= SER_IDLE;
                  end else begin
                     sent_q     <= sent_q + 1'b1;
                     tx_data_q  <= shift_d[NB_DATA-1:0];
                     tx_start_q <= 1'b1;
                     state_q    <= SER_LOAD;
                  end
               end
            end
            default: state_q <= SER_IDLE;
         endcase
      end
   end

   assign tx_start_o = tx_start_q;
   assign tx_data_o  = tx_data_q;
   assign done_o     = (state_q == SER_WAIT) && tx_done_i && (sent_q == LAST_BYTE);

endmodule

// File: rtl/uart_alu_frame_ctrl.sv
// Assembles A, B and opcode from the UART RX byte stream, hands them to the ALU
// atomically with a start pulse, then streams the result back out through TX.
module uart_alu_frame_ctrl
   import uart_alu_pkg::*;
#(
   parameter int NB_DATA        = 8,
   parameter int NB_OPERAND     = 16,
   parameter int NB_OP          = 6,
   parameter int NB_TIMEOUT     = 16,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_rx_valid,
   input  logic [NB_DATA-1:0]    i_rx_data,
   output logic [NB_OPERAND-1:0] o_data_a,
   output logic [NB_OPERAND-1:0] o_data_b,
   output logic [NB_OP-1:0]      o_operation,
   output logic                  o_alu_start,
   input  logic [NB_OPERAND-1:0] i_alu_result,
   output logic                  o_tx_start,
   output logic [NB_DATA-1:0]    o_tx_data,
   input  logic                  i_tx_done,
   output logic                  o_busy,
   output logic                  o_frame_error
);
   localparam int                    N_BYTES  = calc_n_bytes(NB_OPERAND, NB_DATA);
   localparam int                    IDX_W    = idx_width(N_BYTES);
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(N_BYTES - 1);
   localparam bit                    TO_EN    = (TIMEOUT_CYCLES > 0);
   localparam logic [NB_TIMEOUT-1:0] TO_LAST  = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

   if (!params_legal(NB_DATA, NB_OPERAND, NB_OP, NB_TIMEOUT, TIMEOUT_CYCLES)) begin : g_param_check
      $error("uart_alu_frame_ctrl: illegal parameter combination");
   end

   ctrl_state_e           state_q;
   logic [IDX_W-1:0]      idx_q;
   logic [NB_TIMEOUT-1:0] to_cnt_q;
   logic [NB_OPERAND-1:0] shadow_a_q, shadow_b_q;
   logic [NB_OPERAND-1:0] data_a_q, data_b_q;
   logic [NB_OP-1:0]      op_q;
   logic                  alu_start_q, busy_q, frame_error_q;
   logic [N_BYTES-1:0]    lane_sel;
   logic                  to_active, to_expired, ser_done;

   for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_lane_sel
      assign lane_sel[gi] = (idx_q == IDX_W'(gi));
   end

   // The timeout only runs once the current frame holds at least one byte.
   assign to_active  = TO_EN && !i_rx_valid &&
                       (((state_q == ST_RX_A) && (idx_q != '0)) ||
                        (state_q == ST_RX_B) || (state_q == ST_RX_OP));
   assign to_expired = to_active && (to_cnt_q == TO_LAST);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q       <= ST_RX_A;
         idx_q         <= '0;
         to_cnt_q      <= '0;
         shadow_a_q    <= '0;
         shadow_b_q    <= '0;
         data_a_q      <= '0;
         data_b_q      <= '0;
         op_q          <= '0;
         alu_start_q   <= 1'b0;
         busy_q        <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         alu_start_q   <= 1'b0;
         frame_error_q <= 1'b0;
         if (to_active) to_cnt_q <= to_cnt_q + 1'b1;
         case (state_q)
            ST_RX_A, ST_RX_B: begin
               if (i_rx_valid) begin
                  to_cnt_q <= '0;
                  for (int i = 0; i < N_BYTES; i++) begin
                     if (lane_sel[i]) begin
                        if (state_q == ST_RX_A) shadow_a_q[i*NB_DATA +: NB_DATA] <= i_rx_data;
                        else                    shadow_b_q[i*NB_DATA +: NB_DATA] <= i_rx_data;
                     end
                  end
                  if (idx_q == LAST_IDX) begin
                     idx_q   <= '0;
                     state_q <= (state_q == ST_RX_A) ? ST_RX_B : ST_RX_OP;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end else if (to_expired) begin
                  idx_q         <= '0;
                  to_cnt_q      <= '0;
                  frame_error_q <= 1'b1;
                  state_q       <= ST_RX_A;
               end
            end
            ST_RX_OP: begin
               if (i_rx_valid) begin
                  // All three ALU operands switch on this single edge.
                  to_cnt_q    <= '0;
                  data_a_q    <= shadow_a_q;
                  data_b_q    <= shadow_b_q;
                  op_q        <= i_rx_data[NB_OP-1:0];
                  alu_start_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= ST_EXEC;
               end else if (to_expired) begin
                  idx_q         <= '0;
                  to_cnt_q      <= '0;
                  frame_error_q <= 1'b1;
                  state_q       <= ST_RX_A;
               end
            end
            ST_EXEC: state_q <= ST_TX;
            ST_TX: begin
               if (ser_done) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_RX_A;
               end
            end
            default: state_q <= ST_RX_A;
         endcase
      end
   end

   result_tx_serializer #(
      .NB_DATA    (NB_DATA),
      .NB_OPERAND (NB_OPERAND)
   ) u_serializer (
      .clk_i      (i_clock),
      .srst_i     (i_reset),
      .load_i     (state_q == ST_EXEC),
      .result_i   (i_alu_result),
      .tx_done_i  (i_tx_done),
      .tx_start_o (o_tx_start),
      .tx_data_o  (o_tx_data),
      .done_o     (ser_done)
   );

   assign o_data_a      = data_a_q;
   assign o_data_b      = data_b_q;
   assign o_operation   = op_q;
   assign o_alu_start   = alu_start_q;
   assign o_busy        = busy_q;
   assign o_frame_error = frame_error_q;

endmodule
